// File: rtl/decim_ctrl_pkg.sv
// decim_ctrl_pkg
//   Shared definitions for the decimator-chain run controller:
//   sequencer state encoding and default widths.
package decim_ctrl_pkg;

    localparam int DATA_W_DEF = 22;  // chain filter_out width
    localparam int CNT_W_DEF  = 16;  // delivered-sample counter width

    // Sequencer states; encoding is fixed (IDLE=0 .. STREAM=3).
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_STREAM = 2'd3
    } state_t;

endpackage

// File: rtl/decim_out_reg.sv
// decim_out_reg
//   One-entry valid/ready holding register between the decimator chain and
//   the sample sink. The chain cannot be back-pressured, so a sample that
//   arrives while the entry is still held is dropped and flagged.
// Ports
//   clk, reset    clock, synchronous active-high reset
//   load          new chain sample offered this cycle
//   sample        data of the offered sample
//   ready         consumer accepts the held sample
//   clr_overrun   clear the sticky overrun flag
//   data, valid   held sample and its valid flag
//   overrun       sticky: an offered sample was dropped
module decim_out_reg #(
    parameter int DATA_W = 22
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] sample,
    input  logic              ready,
    input  logic              clr_overrun,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              overrun
);

    always_ff @(posedge clk) begin
        if (reset) begin
            data    <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (clr_overrun)
                overrun <= 1'b0;
            // Entry frees up in the same cycle it is handed off, so a new
            // sample can replace the accepted one without a bubble.
            if (load && (!valid || ready)) begin
                data  <= sample;
                valid <= 1'b1;
            end else begin
                if (load)
                    overrun <= 1'b1;   // held sample wins; new one is lost
                if (valid && ready)
                    valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/decim_chain_ctrl.sv
// decim_chain_ctrl
//   Run-control sequencer for the CIC -> HB1 -> HB2 -> HB3 -> FIR decimator.
//   start: flush the chain (chain_reset held FLUSH_CYCLES cycles), enable it,
//   throw away the first SETTLE_SAMPLES outputs (filter transient), then stream
//   samples to the consumer through a one-entry valid/ready register.
// Ports
//   clk, reset             clock, synchronous active-high reset
//   start, stop            1-cycle run-control pulses (stop has priority)
//   chain_ce, chain_reset  clock-enable / reset driven into the chain
//   chain_data/valid       chain filter_out / ce_out
//   m_data/valid/ready     downstream sample stream
//   overrun                sticky sample-dropped flag (cleared by start)
//   busy                   sequencer not idle
//   sample_cnt             delivered-sample count, wraps (cleared by start)
module decim_chain_ctrl
    import decim_ctrl_pkg::*;
#(
    parameter int DATA_W         = DATA_W_DEF,
    parameter int SETTLE_SAMPLES = 8,
    parameter int FLUSH_CYCLES   = 4,
    parameter int CNT_W          = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    output logic              chain_ce,
    output logic              chain_reset,
    input  logic [DATA_W-1:0] chain_data,
    input  logic              chain_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              overrun,
    output logic              busy,
    output logic [CNT_W-1:0]  sample_cnt
);

    localparam logic [7:0] FLUSH_LAST  = 8'(FLUSH_CYCLES - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_SAMPLES - 1);

    state_t     state;
    logic [7:0] flush_cnt;
    logic [7:0] settle_cnt;
    logic       go;
    logic       load;
    logic       handshake;

    // The chain must be held in reset while we are, not one cycle later.
    assign chain_reset = reset || (state == ST_FLUSH);
    assign busy        = (state != ST_IDLE);
    assign go          = (state == ST_IDLE) && start && !stop;
    assign load        = chain_valid && (state == ST_STREAM);
    assign handshake   = m_valid && m_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            chain_ce   <= 1'b0;
            flush_cnt  <= '0;
            settle_cnt <= '0;
            sample_cnt <= '0;
        end else begin
            if (go)
                sample_cnt <= '0;
            else if (handshake)
                sample_cnt <= sample_cnt + 1'b1;

            case (state)
                ST_IDLE: begin
                    if (go) begin
                        state     <= ST_FLUSH;
                        flush_cnt <= '0;
                    end
                end
                ST_FLUSH: begin
                    if (stop) begin
                        state <= ST_IDLE;
                    end else if (flush_cnt == FLUSH_LAST) begin
                        state      <= ST_SETTLE;
                        chain_ce   <= 1'b1;
                        settle_cnt <= '0;
                    end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (stop) begin
                        state    <= ST_IDLE;
                        chain_ce <= 1'b0;
                    end else if (chain_valid) begin
                        // last transient sample is discarded too
                        if (settle_cnt == SETTLE_LAST)
                            state <= ST_STREAM;
                        else
                            settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (stop) begin
                        state    <= ST_IDLE;
                        chain_ce <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    chain_ce <= 1'b0;
                end
            endcase
        end
    end

    decim_out_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .sample      (chain_data),
        .ready       (m_ready),
        .clr_overrun (go),
        .data        (m_data),
        .valid       (m_valid),
        .overrun     (overrun)
    );

endmodule
